pll_cfg_sequencer: RTL and testbench

- Sequences dynamic reconfiguration of the video/system PLL through its Avalon-MM reconfiguration port, using register/value write lists held in an external profile ROM.
- Supervises PLL lock: power-on reset pulse, lock timeout with bounded retry, and lock-loss recovery.
- Sits beside the PLL wrapper and is driven by the core's mode-select logic, for example when switching the pixel clock.

---
 rtl/pll_cfg_sequencer_if.sv | 38 +++
 rtl/pll_cfg_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_pll_cfg_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_cfg_sequencer_if.sv
// ============================================================================
// Module      : pll_cfg_sequencer_if
// Description : Profile ROM read port and PLL reconfiguration write port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface pll_cfg_sequencer_if #(
    parameter int PROF_W   = 2,
    parameter int ENTRY_AW = 4
);
    logic [PROF_W+ENTRY_AW-1:0] rom_addr;
    logic [38:0]                rom_data;
    logic [5:0]                 mgmt_address;
    logic [31:0]                mgmt_writedata;
    logic                       mgmt_write;
    logic                       mgmt_waitrequest;

    modport master (
        output rom_addr,
        output mgmt_address,
        output mgmt_writedata,
        output mgmt_write,
        input  rom_data,
        input  mgmt_waitrequest
    );

    modport slave (
        input  rom_addr,
        input  mgmt_address,
        input  mgmt_writedata,
        input  mgmt_write,
        output rom_data,
        output mgmt_waitrequest
    );
endinterface

`default_nettype wire

// File: rtl/pll_cfg_sequencer.sv
// ============================================================================
// Module      : pll_cfg_sequencer
// Description : Walks a ROM write list into the PLL reconfig port, supervises lock.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pll_cfg_sequencer #(
    parameter int ENTRY_AW     = 4,
    parameter int PROF_W       = 2,
    parameter int LOCK_TIMEOUT = 500000,
    parameter int MAX_RETRY    = 3,
    parameter int RST_CYCLES   = 16
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 cfg_req,
    input  logic [PROF_W-1:0]    cfg_sel,
    pll_cfg_sequencer_if.master  bus,
    input  logic                 locked,
    output logic                 pll_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [7:0]           lock_lost_cnt
);
    localparam int CW = $clog2(RST_CYCLES + 1);
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] c_RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] c_TO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [RW-1:0] c_RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [3:0] c_ST_POR       = 4'd0;
    localparam logic [3:0] c_ST_IDLE      = 4'd1;
    localparam logic [3:0] c_ST_MODE      = 4'd2;
    localparam logic [3:0] c_ST_FETCH     = 4'd3;
    localparam logic [3:0] c_ST_WRITE     = 4'd4;
    localparam logic [3:0] c_ST_START     = 4'd5;
    localparam logic [3:0] c_ST_SETTLE    = 4'd6;
    localparam logic [3:0] c_ST_WAIT_LOCK = 4'd7;
    localparam logic [3:0] c_ST_PULSE     = 4'd8;
    localparam logic [3:0] c_ST_ERROR     = 4'd9;

    logic [3:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [RW-1:0]       retry_q, retry_d;
    logic [PROF_W-1:0]   prof_q, prof_d;
    logic [ENTRY_AW-1:0] idx_q, idx_d;
    logic [7:0]          lost_q, lost_d;
    logic                wr_q, wr_d;
    logic [5:0]          addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic                last_q, last_d;
    logic                lk_meta_q, lk_s_q, lk_prev_q;
    logic                w_lock_fall;
    logic                w_wr_done;

    assign w_lock_fall = lk_prev_q & ~lk_s_q;
    assign w_wr_done   = wr_q & ~bus.mgmt_waitrequest;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= c_ST_POR;
            cnt_q     <= '0;
            timer_q   <= '0;
            retry_q   <= '0;
            prof_q    <= '0;
            idx_q     <= '0;
            lost_q    <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            lk_meta_q <= 1'b0;
            lk_s_q    <= 1'b0;
            lk_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            prof_q    <= prof_d;
            idx_q     <= idx_d;
            lost_q    <= lost_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            last_q    <= last_d;
            lk_meta_q <= locked;
            lk_s_q    <= lk_meta_q;
            lk_prev_q <= lk_s_q;
        end
    end

    // Write states load the bus on their first cycle, then hold until waitrequest drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        retry_d = retry_q;
        prof_d  = prof_q;
        idx_d   = idx_q;
        lost_d  = lost_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            c_ST_POR, c_ST_SETTLE, c_ST_PULSE: begin
                if (cnt_q == c_RST_LAST) begin
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = c_ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            c_ST_IDLE, c_ST_ERROR: begin
                if (cfg_req) begin
                    prof_d  = cfg_sel;
                    idx_d   = '0;
                    retry_d = '0;
                    state_d = c_ST_MODE;
                end else if (state_q == c_ST_IDLE && w_lock_fall) begin
                    if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
                    cnt_d   = '0;
                    state_d = c_ST_PULSE;
                end
            end
            c_ST_MODE: begin
                if (!wr_q) begin
                    wr_d   = 1'b1;
                    addr_d = 6'h00;
                    data_d = 32'h0;
                end else if (w_wr_done) begin
                    wr_d    = 1'b0;
                    idx_d   = '0;
                    state_d = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                state_d = c_ST_WRITE;
            end
            c_ST_WRITE: begin
                if (!wr_q) begin
                    wr_d   = 1'b1;
                    last_d = bus.rom_data[38];
                    addr_d = bus.rom_data[37:32];
                    data_d = bus.rom_data[31:0];
                end else if (w_wr_done) begin
                    wr_d = 1'b0;
                    if (last_q || (&idx_q)) begin
                        state_d = c_ST_START;
                    end else begin
                        idx_d   = idx_q + ENTRY_AW'(1);
                        state_d = c_ST_FETCH;
                    end
                end
            end
            c_ST_START: begin
                if (!wr_q) begin
                    wr_d   = 1'b1;
                    addr_d = 6'h02;
                    data_d = 32'h0;
                end else if (w_wr_done) begin
                    wr_d    = 1'b0;
                    timer_d = '0;
                    cnt_d   = '0;
                    state_d = c_ST_SETTLE;
                end
            end
            c_ST_WAIT_LOCK: begin
                if (lk_s_q) begin
                    state_d = c_ST_IDLE;
                end else if (timer_q == c_TO_LAST) begin
                    timer_d = '0;
                    if (retry_q < c_RETRY_MAX) begin
                        retry_d = retry_q + RW'(1);
                        cnt_d   = '0;
                        state_d = c_ST_PULSE;
                    end else begin
                        state_d = c_ST_ERROR;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = c_ST_POR;
                cnt_d   = '0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_comb begin
        pll_rst            = (state_q == c_ST_POR) || (state_q == c_ST_PULSE);
        busy               = !((state_q == c_ST_IDLE) || (state_q == c_ST_ERROR));
        done               = (state_q == c_ST_WAIT_LOCK) && lk_s_q;
        error              = (state_q == c_ST_ERROR);
        lock_lost_cnt      = lost_q;
        bus.rom_addr       = {prof_q, idx_q};
        bus.mgmt_write     = wr_q;
        bus.mgmt_address   = addr_q;
        bus.mgmt_writedata = data_q;
    end
endmodule

`default_nettype wire

// File: tb/tb_pll_cfg_sequencer.sv
// ============================================================================
// Module      : tb_pll_cfg_sequencer
// Description : Directed bench with a write-order scoreboard for pll_cfg_sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pll_cfg_sequencer;
    localparam int PROF_W   = 2;
    localparam int ENTRY_AW = 4;

    logic       refclk  = 1'b0;
    logic       rst     = 1'b1;
    logic       cfg_req = 1'b0;
    logic [1:0] cfg_sel = 2'd0;
    logic       locked  = 1'b0;
    logic       pll_rst, busy, done, error;
    logic [7:0] lock_lost_cnt;

    pll_cfg_sequencer_if #(.PROF_W(PROF_W), .ENTRY_AW(ENTRY_AW)) bus ();

    pll_cfg_sequencer #(
        .ENTRY_AW(ENTRY_AW), .PROF_W(PROF_W), .LOCK_TIMEOUT(100),
        .MAX_RETRY(3), .RST_CYCLES(16)
    ) dut (
        .refclk(refclk), .rst(rst), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
        .bus(bus), .locked(locked), .pll_rst(pll_rst), .busy(busy),
        .done(done), .error(error), .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 refclk = ~refclk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Profile ROM: 1-cycle read latency; data words encode their own ROM address
    logic [38:0] rom [64];
    always @(posedge refclk) bus.rom_data <= rom[bus.rom_addr];

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = {1'b1, 6'h3F, 32'hDEAD_0000 | 32'(i)};
        rom[6'h00] = {1'b1, 6'h07, 32'hAAAA_0000};
        rom[6'h10] = {1'b0, 6'h04, 32'h1111_0010};
        rom[6'h11] = {1'b0, 6'h05, 32'h1111_0011};
        rom[6'h12] = {1'b1, 6'h06, 32'h1111_0012};
        for (int i = 0; i < 16; i++) rom[6'h30 + i] = {1'b0, 6'(6'h10 + i), 32'h3333_0030 + 32'(i)};
    end

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    task automatic push_wr(input logic [5:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Expected write list: mode write, entries up to last (or forced last at wrap), start write
    task automatic push_profile(input logic [1:0] p);
        logic [38:0] w;
        push_wr(6'h00, 32'h0);
        for (int i = 0; i < 16; i++) begin
            w = rom[{p, 4'(i)}];
            push_wr(w[37:32], w[31:0]);
            if (w[38]) break;
        end
        push_wr(6'h02, 32'h0);
    endtask

    // Waitrequest driver: stalls the write to register 0x05 for 5 cycles when armed
    logic stall_arm = 1'b0;
    int   stall_n   = 5;
    always @(posedge refclk) begin
        #1;
        if (!stall_arm) begin
            stall_n = 5;
            bus.mgmt_waitrequest = 1'b0;
        end else if (bus.mgmt_write && bus.mgmt_address == 6'h05 && stall_n > 0) begin
            bus.mgmt_waitrequest = 1'b1;
            stall_n--;
        end else begin
            bus.mgmt_waitrequest = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on each completed write and checks hold-while-stalled
    logic        prev_wr   = 1'b0;
    logic        prev_wait = 1'b0;
    logic [5:0]  prev_a    = '0;
    logic [31:0] prev_d    = '0;
    logic        prev_pll  = 1'b1;
    int          pulse_cnt = 0;
    int          done_cnt  = 0;
    int          seen05    = 0;
    always @(negedge refclk) begin
        wr_t e;
        if (rst) begin
            prev_wr  = 1'b0;
            prev_pll = 1'b1;
        end else begin
            if (prev_wr && prev_wait)
                check("wr_hold", {bus.mgmt_write, bus.mgmt_address, bus.mgmt_writedata},
                      {1'b1, prev_a, prev_d});
            if (bus.mgmt_write && bus.mgmt_address == 6'h05) seen05++;
            if (bus.mgmt_write && !bus.mgmt_waitrequest) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected none",
                             bus.mgmt_address, bus.mgmt_writedata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr", {bus.mgmt_address, bus.mgmt_writedata}, e);
                end
            end
            if (pll_rst && !prev_pll) pulse_cnt++;
            if (done) done_cnt++;
            prev_wr   = bus.mgmt_write;
            prev_wait = bus.mgmt_waitrequest;
            prev_a    = bus.mgmt_address;
            prev_d    = bus.mgmt_writedata;
            prev_pll  = pll_rst;
        end
    end

    task automatic start_cfg(input logic [1:0] sel);
        @(negedge refclk);
        cfg_sel = sel;
        cfg_req = 1'b1;
        @(negedge refclk);
        cfg_req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge refclk);
            n++;
        end
        check(name, done, 1'b1);
        @(negedge refclk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dbase, pbase;

        // Reset and power-on sequence
        repeat (3) @(negedge refclk);
        check("rst_pll_busy", {pll_rst, busy, done, error}, 4'b1100);
        check("rst_bus", {bus.mgmt_write, bus.mgmt_address, bus.mgmt_writedata}, 39'h0);
        check("rst_rom_cnt", {bus.rom_addr, lock_lost_cnt}, 14'h0);
        rst = 1'b0;
        n = 0;
        while (pll_rst && n < 40) begin
            n++;
            @(negedge refclk);
        end
        check("por_width", 64'(n), 64'd16);
        repeat (10) @(negedge refclk);
        locked = 1'b1;
        n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while (!done && n < 20);
        check("done_latency", 64'(n), 64'd2);
        @(negedge refclk);
        check("por_idle", {busy, done, error}, 3'b000);
        check("por_done_cnt", 64'(done_cnt), 64'd1);

        // Profile 1, no stalls
        dbase = done_cnt;
        push_profile(2'd1);
        start_cfg(2'd1);
        check("cfg_busy", busy, 1'b1);
        wait_done("p1_done", 300);
        check("p1_q_empty", 64'(exp_q.size()), 64'd0);
        check("p1_done_cnt", 64'(done_cnt - dbase), 64'd1);
        check("p1_idle", busy, 1'b0);

        // Profile 1 with entry 0x05 stalled for 5 cycles
        stall_arm = 1'b1;
        seen05 = 0;
        push_profile(2'd1);
        start_cfg(2'd1);
        wait_done("stall_done", 300);
        stall_arm = 1'b0;
        check("stall_cycles", 64'(seen05), 64'd6);
        check("stall_q_empty", 64'(exp_q.size()), 64'd0);

        // Profile 3 wraps at 16 entries; a cfg_req while busy must be dropped
        push_profile(2'd3);
        start_cfg(2'd3);
        repeat (6) @(negedge refclk);
        cfg_sel = 2'd0;
        cfg_req = 1'b1;
        @(negedge refclk);
        cfg_req = 1'b0;
        wait_done("p3_done", 500);
        check("p3_q_empty", 64'(exp_q.size()), 64'd0);

        // Lock lost in the same cycle cfg_req is seen, then lock never returns
        pbase = pulse_cnt;
        push_profile(2'd0);
        @(negedge refclk);
        locked = 1'b0;
        repeat (2) @(negedge refclk);
        cfg_sel = 2'd0;
        cfg_req = 1'b1;
        @(negedge refclk);
        cfg_req = 1'b0;
        n = 0;
        while (!error && n < 2000) begin
            @(negedge refclk);
            n++;
        end
        check("err_set", error, 1'b1);
        check("err_busy", busy, 1'b0);
        check("err_pulses", 64'(pulse_cnt - pbase), 64'd3);
        check("err_loss_not_counted", lock_lost_cnt, 8'd0);
        check("err_q_empty", 64'(exp_q.size()), 64'd0);
        locked = 1'b1;
        repeat (4) @(negedge refclk);
        check("err_sticky", error, 1'b1);

        // cfg_req from ERROR clears error and reconfigures
        push_profile(2'd1);
        start_cfg(2'd1);
        check("err_cleared", error, 1'b0);
        wait_done("recfg_done", 300);
        check("recfg_q_empty", 64'(exp_q.size()), 64'd0);

        // Single-cycle lock loss in IDLE
        pbase = pulse_cnt;
        dbase = done_cnt;
        @(negedge refclk);
        locked = 1'b0;
        @(negedge refclk);
        locked = 1'b1;
        wait_done("loss_done", 100);
        check("loss_cnt", lock_lost_cnt, 8'd1);
        check("loss_pulses", 64'(pulse_cnt - pbase), 64'd1);
        check("loss_done_cnt", 64'(done_cnt - dbase), 64'd1);
        check("loss_no_writes", 64'(exp_q.size()), 64'd0);

        // 299 more losses: counter saturates
        for (int i = 0; i < 299; i++) begin
            @(negedge refclk);
            locked = 1'b0;
            @(negedge refclk);
            locked = 1'b1;
            n = 0;
            while (!done && n < 100) begin
                @(negedge refclk);
                n++;
            end
            if (!done) begin
                checks++;
                failures++;
                $display("FAIL loss_iter_done: got no done expected done at iteration %0d", i);
                break;
            end
            @(negedge refclk);
        end
        check("loss_sat", lock_lost_cnt, 8'd255);
        check("loss_total_pulses", 64'(pulse_cnt - pbase), 64'd300);
        check("final_idle", {busy, error}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
